// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-vector result path.
//   MM_N / MM_DW : lane count and lane width of the matrix unit
//   row_t        : one full result row, lane i at [(i+1)*MM_DW-1 : i*MM_DW]
//   lane_slice() : extracts lane i from a packed row
package mm_pkg;
   localparam int MM_N  = 16;
   localparam int MM_DW = 32;

   typedef logic [MM_DW*MM_N-1:0] row_t;

   function automatic logic [MM_DW-1:0] lane_slice(input row_t r, input int unsigned i);
      return r[i*MM_DW +: MM_DW];
   endfunction
endpackage

// File: rtl/mm_row_collector_if.sv
// Row output stream of the collector (valid/ready with last-row-of-tile tag).
//   out_data  : assembled row
//   out_valid : head row valid
//   out_ready : consumer accepts the head row
//   out_last  : head row closes its tile
interface mm_row_collector_if #(
   parameter int DW = 32,
   parameter int N  = 16
);
   logic [DW*N-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic            out_last;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/mm_row_fifo.sv
// First-word-fall-through row FIFO.
//   i_push/i_wdata : write an entry (caller guarantees a free slot or a same-cycle pop)
//   i_pop          : retire the head (caller guarantees non-empty)
//   o_rdata        : head entry, valid whenever !o_empty
//   o_full/o_empty/o_count : occupancy status
//   i_clr          : synchronous flush
module mm_row_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 513
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  logic [W-1:0]             i_wdata,
   input  logic                     i_pop,
   output logic [W-1:0]             o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // DEPTH is a power of 2, so pointers wrap naturally
         if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
   end

   // Storage needs no reset: the read side is qualified by occupancy.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
endmodule

// File: rtl/mm_row_collector.sv
// Collects per-lane results of the matrix-vector unit into full rows, buffers
// them in a FWFT FIFO and streams them out with last-row-of-tile marking.
//   clk, rst_n (async low), clear (sync flush)
//   vector_in/lane_valid : per-lane results and one-cycle strobes
//   row_if               : output row stream (master side)
//   almost_full          : registered throttle, occupancy >= DEPTH-AF_MARGIN
//   tile_done/row_count  : tile progress
//   overrun_err/overflow_err : sticky misuse flags
module mm_row_collector
   import mm_pkg::*;
#(
   parameter int N             = MM_N,
   parameter int DW            = MM_DW,
   parameter int DEPTH         = 8,
   parameter int AF_MARGIN     = 2,
   parameter int ROWS_PER_TILE = 16
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clear,
   input  logic [DW*N-1:0]                  vector_in,
   input  logic [N-1:0]                     lane_valid,
   mm_row_collector_if.master               row_if,
   output logic                             almost_full,
   output logic                             tile_done,
   output logic [$clog2(ROWS_PER_TILE)-1:0] row_count,
   output logic                             overrun_err,
   output logic                             overflow_err
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int RW = $clog2(ROWS_PER_TILE);
   localparam int FW = DW*N + 1;

   logic [N-1:0]    w_mask;
   logic [DW*N-1:0] w_row;
   logic            w_complete;
   logic            w_overrun;
   logic            w_full, w_empty;
   logic            w_pop, w_push, w_drop, w_last;
   logic [CW-1:0]   w_count, w_count_nxt;
   logic [FW-1:0]   w_rdata;

   logic            r_af, r_td, r_ovr, r_ovf;
   logic [RW-1:0]   r_rc;

   // Per-lane capture register and arrival mask.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_lane
         logic [DW-1:0] r_cap;
         logic          r_mask;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_cap  <= '0;
               r_mask <= 1'b0;
            end else if (clear) begin
               r_cap  <= '0;
               r_mask <= 1'b0;
            end else if (w_complete) begin
               r_mask <= 1'b0;
            end else if (lane_valid[gi] && !r_mask) begin
               r_cap  <= lane_slice(vector_in, gi);
               r_mask <= 1'b1;
            end
         end
         assign w_mask[gi] = r_mask;
         // A lane strobing in the completion cycle bypasses its register.
         assign w_row[gi*DW +: DW] = lane_valid[gi] ? lane_slice(vector_in, gi) : r_cap;
      end
   endgenerate

   assign w_complete = &(w_mask | lane_valid);
   assign w_overrun  = !w_complete && |(lane_valid & w_mask);

   assign w_pop       = !w_empty && row_if.out_ready;
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_push      = w_complete && (!w_full || w_pop);
   assign w_drop      = w_complete && w_full && !w_pop;
   assign w_last      = (r_rc == RW'(ROWS_PER_TILE-1));
   assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

   mm_row_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (clear),
      .i_push  (w_push),
      .i_wdata ({w_last, w_row}),
      .i_pop   (w_pop),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_af  <= 1'b0;
         r_td  <= 1'b0;
         r_rc  <= '0;
         r_ovr <= 1'b0;
         r_ovf <= 1'b0;
      end else if (clear) begin
         r_af  <= 1'b0;
         r_td  <= 1'b0;
         r_rc  <= '0;
         r_ovr <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         r_af <= (w_count_nxt >= CW'(DEPTH-AF_MARGIN));
         r_td <= w_push && w_last;
         if (w_push) r_rc <= w_last ? '0 : r_rc + RW'(1);
         if (w_overrun) r_ovr <= 1'b1;
         if (w_drop)    r_ovf <= 1'b1;
      end
   end

   // Output qualified by occupancy so an empty FIFO presents zeros.
   assign row_if.out_valid = !w_empty;
   assign row_if.out_data  = w_empty ? '0 : w_rdata[DW*N-1:0];
   assign row_if.out_last  = !w_empty && w_rdata[DW*N];

   assign almost_full  = r_af;
   assign tile_done    = r_td;
   assign row_count    = r_rc;
   assign overrun_err  = r_ovr;
   assign overflow_err = r_ovf;
endmodule

// File: tb/tb_mm_row_collector.sv
module tb_mm_row_collector;
   import mm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   row_t        vector_in = '0;
   logic [15:0] lane_valid = '0;
   logic [1:0]  rdy = '0;
   logic        af16, td16, ovr16, ovf16, af4, td4, ovr4, ovf4;
   logic [3:0]  rc16;
   logic [1:0]  rc4;
   int          nvec = 0;
   int          nerr = 0;

   mm_row_collector_if if16 ();
   mm_row_collector_if if4 ();
   assign if16.out_ready = rdy[0];
   assign if4.out_ready  = rdy[1];

   mm_row_collector #(.DEPTH(8), .AF_MARGIN(2), .ROWS_PER_TILE(16)) u16 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .vector_in(vector_in),
      .lane_valid(lane_valid), .row_if(if16), .almost_full(af16), .tile_done(td16),
      .row_count(rc16), .overrun_err(ovr16), .overflow_err(ovf16));

   mm_row_collector #(.DEPTH(8), .AF_MARGIN(2), .ROWS_PER_TILE(4)) u4 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .vector_in(vector_in),
      .lane_valid(lane_valid), .row_if(if4), .almost_full(af4), .tile_done(td4),
      .row_count(rc4), .overrun_err(ovr4), .overflow_err(ovf4));

   always #5 clk = ~clk;

   // Reference model: capture state is shared (same inputs), row queues per instance.
   logic [15:0] m_mask;
   logic [31:0] m_cap [16];
   bit          m_ovr;
   row_t        m_q  [2][$];
   bit          m_ql [2][$];
   int          m_rc [2];
   bit          m_td [2];
   bit          m_ovf[2];
   bit          m_af [2];

   function automatic int rpt(input int k);
      return (k == 0) ? 16 : 4;
   endfunction

   function automatic row_t mkrow(input logic [31:0] base, input logic [31:0] step);
      row_t r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = base + step * 32'(i);
      return r;
   endfunction

   task automatic model_reset();
      m_mask = '0;
      m_ovr  = 1'b0;
      for (int i = 0; i < 16; i++) m_cap[i] = '0;
      for (int k = 0; k < 2; k++) begin
         m_q[k].delete();
         m_ql[k].delete();
         m_rc[k] = 0; m_td[k] = 0; m_ovf[k] = 0; m_af[k] = 0;
      end
   endtask

   // Effect of the coming clock edge given the inputs currently applied.
   task automatic model_edge();
      bit   comp;
      bit   last;
      row_t row;
      if (clear) begin
         model_reset();
         return;
      end
      comp = ((m_mask | lane_valid) == 16'hFFFF);
      for (int i = 0; i < 16; i++)
         row[i*32 +: 32] = lane_valid[i] ? vector_in[i*32 +: 32] : m_cap[i];
      if (comp) m_mask = '0;
      else begin
         for (int i = 0; i < 16; i++) begin
            if (lane_valid[i]) begin
               if (m_mask[i]) m_ovr = 1'b1;
               else begin
                  m_cap[i]  = vector_in[i*32 +: 32];
                  m_mask[i] = 1'b1;
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         if (m_q[k].size() > 0 && rdy[k]) begin
            void'(m_q[k].pop_front());
            void'(m_ql[k].pop_front());
         end
         m_td[k] = 1'b0;
         if (comp) begin
            if (m_q[k].size() < 8) begin
               last = (m_rc[k] == rpt(k) - 1);
               m_q[k].push_back(row);
               m_ql[k].push_back(last);
               m_rc[k] = last ? 0 : m_rc[k] + 1;
               m_td[k] = last;
            end else m_ovf[k] = 1'b1;
         end
         m_af[k] = (m_q[k].size() >= 6);
      end
   endtask

   task automatic chk(input string tag, input row_t obs, input row_t exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic v, l, af, td, ovr, ovf;
      row_t d;
      int   rc;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            v = if16.out_valid; d = if16.out_data; l = if16.out_last;
            af = af16; td = td16; rc = int'(rc16); ovr = ovr16; ovf = ovf16;
         end else begin
            v = if4.out_valid; d = if4.out_data; l = if4.out_last;
            af = af4; td = td4; rc = int'(rc4); ovr = ovr4; ovf = ovf4;
         end
         chk($sformatf("%s.valid%0d", tag, k), row_t'(v), row_t'(m_q[k].size() > 0));
         chk($sformatf("%s.data%0d", tag, k), d, (m_q[k].size() > 0) ? m_q[k][0] : '0);
         chk($sformatf("%s.last%0d", tag, k), row_t'(l),
             row_t'((m_q[k].size() > 0) ? m_ql[k][0] : 1'b0));
         chk($sformatf("%s.af%0d", tag, k), row_t'(af), row_t'(m_af[k]));
         chk($sformatf("%s.td%0d", tag, k), row_t'(td), row_t'(m_td[k]));
         chk($sformatf("%s.rc%0d", tag, k), row_t'(rc), row_t'(m_rc[k]));
         chk($sformatf("%s.ovr%0d", tag, k), row_t'(ovr), row_t'(m_ovr));
         chk($sformatf("%s.ovf%0d", tag, k), row_t'(ovf), row_t'(m_ovf[k]));
      end
   endtask

   // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
   task automatic cyc(input logic [15:0] lv, input row_t v, input string tag);
      lane_valid = lv;
      vector_in  = v;
      model_edge();
      @(posedge clk);
      #1;
      lane_valid = '0;
      check_all(tag);
   endtask

   initial begin
      row_t        v;
      row_t        rv;
      logic [15:0] lv;
      int          tdcnt;

      model_reset();
      #2 rst_n = 1'b0;
      #2 check_all("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // all lanes in one cycle
      rdy = 2'b11;
      cyc(16'hFFFF, mkrow(32'h1000_0000, 32'h1), "simul");
      chk("simul_valid", row_t'(if16.out_valid), row_t'(1'b1));
      chk("simul_lane5", row_t'(lane_slice(if16.out_data, 5)), row_t'(32'h1000_0005));
      chk("simul_err", row_t'({ovr16, ovf16}), '0);
      cyc(16'h0, '0, "idle");

      // one lane per cycle
      v = mkrow(32'h2000_0000, 32'h11);
      for (int i = 0; i < 16; i++) begin
         cyc(16'h1 << i, v, "stag");
         if (i == 14) chk("stag_early", row_t'(if16.out_valid), '0);
      end
      chk("stag_valid", row_t'(if16.out_valid), row_t'(1'b1));
      chk("stag_data", if16.out_data, v);
      cyc(16'h0, '0, "idle");

      // lane 3 strobes twice before the row completes
      cyc(16'h0008, mkrow(32'hA0A0_0000, 32'h0), "ovrA");
      cyc(16'h0008, mkrow(32'hB0B0_0000, 32'h0), "ovrB");
      cyc(16'hFFF7, mkrow(32'h3000_0000, 32'h1), "ovrC");
      chk("ovr_flag", row_t'(ovr16), row_t'(1'b1));
      chk("ovr_lane3", row_t'(lane_slice(if16.out_data, 3)), row_t'(32'hA0A0_0000));
      cyc(16'h0, '0, "idle");

      // synchronous clear, then backpressure and overflow
      clear = 1'b1;
      cyc(16'h0, '0, "clear");
      clear = 1'b0;
      chk("clr_ovr", row_t'(ovr16), '0);
      rdy = 2'b00;
      for (int r = 0; r < 9; r++) begin
         cyc(16'hFFFF, mkrow(32'h4000_0000 + 32'(r << 8), 32'h1), "bp");
         if (r == 4) chk("af_at5", row_t'(af16), '0);
         if (r == 5) chk("af_at6", row_t'(af16), row_t'(1'b1));
         if (r == 7) chk("ovf_at8", row_t'(ovf16), '0);
      end
      chk("ovf_flag", row_t'(ovf16), row_t'(1'b1));
      chk("rc_at8", row_t'(rc16), row_t'(4'd8));
      rdy = 2'b11;
      for (int r = 0; r < 8; r++) begin
         chk("pop_order", row_t'(lane_slice(if16.out_data, 0)), row_t'(32'h4000_0000 + 32'(r << 8)));
         cyc(16'h0, '0, "drain");
      end
      chk("drained", row_t'(if16.out_valid), '0);

      // tile marking with 4 rows per tile
      clear = 1'b1;
      cyc(16'h0, '0, "clear");
      clear = 1'b0;
      tdcnt = 0;
      for (int r = 0; r < 5; r++) begin
         cyc(16'hFFFF, mkrow(32'h5000_0000 + 32'(r << 8), 32'h1), "tile");
         chk("tile_last", row_t'(if4.out_last), row_t'(r == 3));
         tdcnt += int'(td4);
      end
      cyc(16'h0, '0, "idle");
      tdcnt += int'(td4);
      chk("tile_done_cnt", row_t'(tdcnt), row_t'(1));
      chk("tile_rc", row_t'(rc4), row_t'(2'd1));

      // asynchronous reset in the middle of a row
      rdy = 2'b00;
      cyc(16'hFFFF, mkrow(32'h6100_0000, 32'h1), "pre_rst");
      cyc(16'h007F, mkrow(32'h6000_0000, 32'h1), "part");
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("arst");
      chk("arst_valid", row_t'(if16.out_valid), '0);
      @(posedge clk); #1 rst_n = 1'b1;
      rdy = 2'b11;
      v = mkrow(32'h7000_0000, 32'h3);
      cyc(16'hFF00, v, "post_hi");
      chk("no_stale_push", row_t'(if16.out_valid), '0);
      cyc(16'h00FF, v, "post_lo");
      chk("clean_row", if16.out_data, v);
      cyc(16'h0, '0, "post_idle");
      chk("no_extra", row_t'(if16.out_valid), '0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         rdy   = 2'($urandom);
         clear = ($urandom_range(0, 63) == 0);
         case ($urandom_range(0, 3))
            0:       lv = 16'hFFFF;
            1:       lv = 16'($urandom);
            default: lv = 16'($urandom & $urandom & $urandom);
         endcase
         for (int i = 0; i < 16; i++) rv[i*32 +: 32] = $urandom;
         cyc(lv, rv, "rand");
         clear = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
